camera_stream_packer: RTL

//  Upstream neighbour of the frame uploader. Converts the OV7670 byte stream into the
//  17-bit pixel queue: two bytes form one RGB565 word with bit16=0. Control tokens
//  are 17'h10000 (start frame), 17'h10001 (start row) and 17'h1FFFF (end frame).

---
 rtl/camera_stream_packer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/camera_stream_packer.sv
// Packs the OV7670 byte stream into 17-bit RGB565 words and frame/row control tokens
// for a show-ahead pixel queue. All queue writes are registered one cycle after the sampled input.
module camera_stream_packer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_byte_valid,
  input  logic [7:0]  cam_data,
  input  logic        queue_full,
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  output logic        frame_done,
  output logic        frame_error,
  output logic        overflow
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_VSYNC = 2'd1;
  localparam logic [1:0] WAIT_ROW   = 2'd2;
  localparam logic [1:0] ROW        = 2'd3;

  localparam logic [16:0] TOK_SOF = 17'h10000;
  localparam logic [16:0] TOK_SOR = 17'h10001;
  localparam logic [16:0] TOK_EOF = 17'h1FFFF;

  localparam logic [10:0] WIDTH_L  = 11'(FRAME_WIDTH);
  localparam logic [10:0] HEIGHT_L = 11'(FRAME_HEIGHT);

  logic [1:0]  state, state_n;
  logic        prev_vsync, prev_href;
  logic [10:0] col, col_n, row, row_n, row_inc;
  logic        phase, phase_n;
  logic [7:0]  hi, hi_n;
  logic        wr_due, done_n, err_n;
  logic [16:0] wr_word;
  logic        vs_fall, vs_rise, hr_rise, hr_fall, byte_ok;

  assign vs_fall = prev_vsync & ~cam_vsync;
  assign vs_rise = ~prev_vsync & cam_vsync;
  assign hr_rise = ~prev_href & cam_href;
  assign hr_fall = prev_href & ~cam_href;
  assign byte_ok = cam_byte_valid & cam_href;
  assign row_inc = row + 11'd1;

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    phase_n = phase;
    hi_n    = hi;
    wr_due  = 1'b0;
    wr_word = 17'h0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (enable) state_n = WAIT_VSYNC;
      WAIT_VSYNC: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (vs_fall) begin
          wr_due  = 1'b1;
          wr_word = TOK_SOF;
          row_n   = 11'd0;
          state_n = WAIT_ROW;
        end
      end
      WAIT_ROW: begin
        if (hr_rise) begin
          wr_due  = 1'b1;
          wr_word = TOK_SOR;
          col_n   = 11'd0;
          phase_n = 1'b0;
          state_n = ROW;
          // A byte on the href rising cycle is the row's first (high) byte.
          if (byte_ok) begin
            hi_n    = cam_data;
            phase_n = 1'b1;
          end
        end else if (vs_rise && row < HEIGHT_L) begin
          wr_due  = 1'b1;
          wr_word = TOK_EOF;
          err_n   = 1'b1;
          state_n = enable ? WAIT_VSYNC : IDLE;
        end
      end
      ROW: begin
        if (hr_fall) begin
          row_n   = row_inc;
          phase_n = 1'b0;
          if (phase || col < WIDTH_L) err_n = 1'b1;
          if (row_inc == HEIGHT_L) begin
            wr_due  = 1'b1;
            wr_word = TOK_EOF;
            done_n  = 1'b1;
            state_n = enable ? WAIT_VSYNC : IDLE;
          end else begin
            state_n = WAIT_ROW;
          end
        end else if (byte_ok) begin
          if (!phase) begin
            hi_n    = cam_data;
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (col < WIDTH_L) begin
              wr_due  = 1'b1;
              wr_word = {1'b0, hi, cam_data};
            end
            if (col != 11'h7FF) col_n = col + 11'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prev_vsync  <= 1'b0;
      prev_href   <= 1'b0;
      col         <= 11'd0;
      row         <= 11'd0;
      phase       <= 1'b0;
      hi          <= 8'd0;
      queue_wr_en <= 1'b0;
      queue_data  <= 17'h0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      prev_vsync  <= cam_vsync;
      prev_href   <= cam_href;
      col         <= col_n;
      row         <= row_n;
      phase       <= phase_n;
      hi          <= hi_n;
      // A write lost to a full queue still advances state; only overflow records it.
      queue_wr_en <= wr_due & ~queue_full;
      if (wr_due && !queue_full) queue_data <= wr_word;
      if (wr_due && queue_full) overflow <= 1'b1;
      frame_done  <= done_n;
      frame_error <= err_n;
    end
  end

endmodule
